// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button / DIP-switch reader.
//   btn_evt_e     : encoding of event_type_o (press, release, long press;
//                   2'b11 is reserved and never produced)
//   ms_tick_count : terminal count of the 1 ms prescaler for a clock given
//                   in MHz (the prescaler counts 0..terminal inclusive)
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    BTN_EVT_PRESS   = 2'b00,
    BTN_EVT_RELEASE = 2'b01,
    BTN_EVT_LONG    = 2'b10
  } btn_evt_e;

  function automatic int unsigned ms_tick_count(input int unsigned clk_in_mhz);
    return clk_in_mhz * 1000 - 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One input channel of the button/switch reader: two-flop synchroniser,
// polarity normalisation, tick-based debounce counter, accepted level and
// registered one-cycle edge pulses. With BTN_LONG_PRESS_EN defined it also
// keeps a saturating hold counter and emits a single long-press pulse per
// press; without it long_o is constant 0 and LONG_PRESS_MS has no effect.
//
// Ports
//   clk_i     : system clock
//   rst_i     : synchronous reset, active-high
//   tick_i    : shared 1 ms tick, one cycle wide
//   raw_i     : raw asynchronous pin
//   stable_o  : debounced level, 1 = pressed
//   press_o   : one-cycle pulse in the cycle stable_o rises
//   release_o : one-cycle pulse in the cycle stable_o falls
//   long_o    : one-cycle pulse when the hold time is reached
// -----------------------------------------------------------------------------
module btn_debounce
  import btn_pkg::*;
#(
  parameter logic        INPUT_POLARITY = 1'b0,
  parameter int unsigned DEBOUNCE_MS    = 10,
  parameter int unsigned LONG_PRESS_MS  = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_MS + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             sync_n;
  logic [CNT_W-1:0] cnt_q;

  // Synchroniser flops come out of reset at the released pin level so that
  // leaving reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= ~INPUT_POLARITY;
      sync2_q <= ~INPUT_POLARITY;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // 1 = pressed, whatever the electrical polarity of the pin.
  assign sync_n = sync2_q ^ ~INPUT_POLARITY;

  // A changed level is accepted only after DEBOUNCE_MS consecutive ticks of
  // disagreement; any single cycle of agreement restarts the count, which
  // is what swallows contact bounce.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      stable_o  <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      press_o   <= 1'b0;
      release_o <= 1'b0;
      if (sync_n == stable_o) begin
        cnt_q <= '0;
      end else if (tick_i) begin
        if (cnt_q == CNT_W'(DEBOUNCE_MS - 1)) begin
          cnt_q     <= '0;
          stable_o  <= sync_n;
          press_o   <= sync_n;
          release_o <= ~sync_n;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_MS + 1);

  logic [HOLD_W-1:0] hold_q;

  // Hold counter saturates at LONG_PRESS_MS, so the pulse on the increment
  // that reaches it can only happen once until the button is released.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
      long_o <= 1'b0;
    end else if (!stable_o) begin
      hold_q <= '0;
      long_o <= 1'b0;
    end else begin
      long_o <= 1'b0;
      if (tick_i && (hold_q != HOLD_W'(LONG_PRESS_MS))) begin
        hold_q <= hold_q + HOLD_W'(1);
        long_o <= (hold_q == HOLD_W'(LONG_PRESS_MS - 1));
      end
    end
  end
`else
  // No long-press detection in this build; the parameter is referenced only
  // so that it remains a legal but ignored setting.
  assign long_o = 1'b0 && (LONG_PRESS_MS != 0);
`endif

endmodule

// File: rtl/btn_sw_reader.sv
// -----------------------------------------------------------------------------
// btn_sw_reader
// Reads NUM_INPUTS raw button/switch pins: synchronises and debounces each
// one on a shared 1 ms tick, publishes debounced levels and edge pulses, and
// queues press / release / long-press events into a valid/ready stream.
// Optional long-press detection is enabled by defining BTN_LONG_PRESS_EN.
//
// Ports
//   clk_i         : system clock
//   rst_i         : synchronous reset, active-high
//   btn_raw_i     : raw asynchronous pins
//   btn_state_o   : debounced levels, 1 = pressed
//   press_o       : one-cycle pulse per accepted press
//   release_o     : one-cycle pulse per accepted release
//   event_valid_o : event word available
//   event_ready_i : consumer accepts the event word
//   event_idx_o   : input index of the event
//   event_type_o  : 00 press, 01 release, 10 long press
//   overflow_o    : sticky, an event was dropped on a full pending bit
//   ovf_clr_i     : clears overflow_o
// -----------------------------------------------------------------------------
module btn_sw_reader
  import btn_pkg::*;
#(
  parameter int unsigned CLK_IN_MHZ     = 100,
  parameter int unsigned NUM_INPUTS     = 8,
  parameter logic        INPUT_POLARITY = 1'b0,
  parameter int unsigned DEBOUNCE_MS    = 10,
  parameter int unsigned LONG_PRESS_MS  = 1000,
  localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_INPUTS-1:0] btn_raw_i,
  output logic [NUM_INPUTS-1:0] btn_state_o,
  output logic [NUM_INPUTS-1:0] press_o,
  output logic [NUM_INPUTS-1:0] release_o,
  output logic                  event_valid_o,
  input  logic                  event_ready_i,
  output logic [IDX_W-1:0]      event_idx_o,
  output logic [1:0]            event_type_o,
  output logic                  overflow_o,
  input  logic                  ovf_clr_i
);

  localparam int unsigned TICK_TC = ms_tick_count(CLK_IN_MHZ);
  localparam int unsigned PRE_W   = (TICK_TC > 0) ? $clog2(TICK_TC + 1) : 1;

  logic [PRE_W-1:0]      presc_q;
  logic                  tick;
  logic [NUM_INPUTS-1:0] long_pulse;

  logic [NUM_INPUTS-1:0] pend_press;
  logic [NUM_INPUTS-1:0] pend_rel;
  logic [NUM_INPUTS-1:0] pend_long;

  logic                  load_en;
  logic                  any_pend;
  logic [IDX_W-1:0]      sel_idx;
  logic [1:0]            sel_type;
  logic [NUM_INPUTS-1:0] sel_onehot;
  logic [NUM_INPUTS-1:0] clr_press;
  logic [NUM_INPUTS-1:0] clr_rel;
  logic [NUM_INPUTS-1:0] clr_long;
  logic [NUM_INPUTS-1:0] ovf_hit;

  // Free-running 1 ms prescaler; tick is its terminal count.
  assign tick = (presc_q == PRE_W'(TICK_TC));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
    btn_debounce #(
      .INPUT_POLARITY (INPUT_POLARITY),
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .LONG_PRESS_MS  (LONG_PRESS_MS)
    ) u_db (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .tick_i    (tick),
      .raw_i     (btn_raw_i[gi]),
      .stable_o  (btn_state_o[gi]),
      .press_o   (press_o[gi]),
      .release_o (release_o[gi]),
      .long_o    (long_pulse[gi])
    );
  end

  // The output register may take a new word when it is empty or when the
  // current word is being accepted this cycle, giving back-to-back events.
  assign load_en = !event_valid_o || event_ready_i;

  // Priority pick: the loop walks downwards so the lowest pending index is
  // the last writer. Within one index press beats long beats release.
  always_comb begin
    any_pend   = 1'b0;
    sel_idx    = '0;
    sel_type   = BTN_EVT_PRESS;
    sel_onehot = '0;
    for (int i = int'(NUM_INPUTS) - 1; i >= 0; i--) begin
      if (pend_press[i] || pend_long[i] || pend_rel[i]) begin
        any_pend      = 1'b1;
        sel_idx       = IDX_W'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        if (pend_press[i]) begin
          sel_type = BTN_EVT_PRESS;
        end else if (pend_long[i]) begin
          sel_type = BTN_EVT_LONG;
        end else begin
          sel_type = BTN_EVT_RELEASE;
        end
      end
    end
  end

  assign clr_press = (load_en && (sel_type == BTN_EVT_PRESS))   ? sel_onehot : '0;
  assign clr_long  = (load_en && (sel_type == BTN_EVT_LONG))    ? sel_onehot : '0;
  assign clr_rel   = (load_en && (sel_type == BTN_EVT_RELEASE)) ? sel_onehot : '0;

  // A pulse landing on a bit that is still set and not leaving this cycle
  // has nowhere to go and is lost.
  assign ovf_hit = (press_o    & pend_press & ~clr_press)
                 | (release_o  & pend_rel   & ~clr_rel)
                 | (long_pulse & pend_long  & ~clr_long);

  // Pending set: the loaded bit clears, a new pulse sets. A pulse on the bit
  // being loaded in the same cycle therefore keeps it set for a second event.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_press <= '0;
      pend_rel   <= '0;
      pend_long  <= '0;
    end else begin
      pend_press <= (pend_press & ~clr_press) | press_o;
      pend_rel   <= (pend_rel   & ~clr_rel)   | release_o;
      pend_long  <= (pend_long  & ~clr_long)  | long_pulse;
    end
  end

  // Event word register; contents only move when load_en allows, so the
  // word is frozen while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      event_valid_o <= 1'b0;
      event_idx_o   <= '0;
      event_type_o  <= 2'b00;
    end else if (load_en) begin
      event_valid_o <= any_pend;
      if (any_pend) begin
        event_idx_o  <= sel_idx;
        event_type_o <= sel_type;
      end
    end
  end

  // Sticky overflow flag; a fresh overflow outranks a clear request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
    end else if (|ovf_hit) begin
      overflow_o <= 1'b1;
    end else if (ovf_clr_i) begin
      overflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_sw_reader.sv
// -----------------------------------------------------------------------------
// tb_btn_sw_reader
// Directed bench for btn_sw_reader at CLK_IN_MHZ=1 (1000 cycles per ms),
// NUM_INPUTS=4, DEBOUNCE_MS=3, LONG_PRESS_MS=5, active-low pins.
// Expectations for long-press events follow BTN_LONG_PRESS_EN.
// -----------------------------------------------------------------------------
module tb_btn_sw_reader;

  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] btn_raw_i = 4'hF;
  logic [N-1:0] btn_state_o;
  logic [N-1:0] press_o;
  logic [N-1:0] release_o;
  logic         event_valid_o;
  logic         event_ready_i = 1'b1;
  logic [1:0]   event_idx_o;
  logic [1:0]   event_type_o;
  logic         overflow_o;
  logic         ovf_clr_i = 1'b0;

  int vectors    = 0;
  int miscompares = 0;

  btn_sw_reader #(
    .CLK_IN_MHZ     (1),
    .NUM_INPUTS     (N),
    .INPUT_POLARITY (1'b0),
    .DEBOUNCE_MS    (3),
    .LONG_PRESS_MS  (5)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .btn_raw_i     (btn_raw_i),
    .btn_state_o   (btn_state_o),
    .press_o       (press_o),
    .release_o     (release_o),
    .event_valid_o (event_valid_o),
    .event_ready_i (event_ready_i),
    .event_idx_o   (event_idx_o),
    .event_type_o  (event_type_o),
    .overflow_o    (overflow_o),
    .ovf_clr_i     (ovf_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Cycle counter for event timestamps.
  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Records every handshaken event word (idx, type, cycle).
  typedef struct packed {
    logic [1:0]  idx;
    logic [1:0]  typ;
    logic [31:0] cyc;
  } ev_t;

  ev_t evq[$];
  ev_t mon_ev;

  always @(negedge clk_i) begin
    if (!rst_i && event_valid_o && event_ready_i) begin
      mon_ev.idx = event_idx_o;
      mon_ev.typ = event_type_o;
      mon_ev.cyc = cyc;
      evq.push_back(mon_ev);
    end
  end

  function automatic logic [3:0] ev_at(input int i);
    if (i < evq.size()) return {evq[i].idx, evq[i].typ};
    return 4'hF;
  endfunction

  task automatic test_reset();
    int act;
    rst_i     = 1'b1;
    btn_raw_i = 4'hF;
    repeat (3) @(negedge clk_i);
    vectors++;
    if ({event_valid_o, event_idx_o, event_type_o, overflow_o} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_evt: got v=%b i=%0d t=%b o=%b want all 0",
               event_valid_o, event_idx_o, event_type_o, overflow_o);
    end
    vectors++;
    if ({btn_state_o, press_o, release_o} !== 12'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_lvl: got st=%b pr=%b rl=%b want 0",
               btn_state_o, press_o, release_o);
    end
    rst_i = 1'b0;
    evq.delete();
    act = 0;
    repeat (20000) begin
      @(negedge clk_i);
      if (event_valid_o || (press_o != 0) || (release_o != 0) || (btn_state_o != 0)) act++;
    end
    vectors++;
    if (act !== 0) begin
      miscompares++;
      $display("[TB] FAIL idle_activity: got %0d active cycles want 0", act);
    end
    vectors++;
    if (evq.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL idle_events: got %0d events want 0", evq.size());
    end
  endtask

  task automatic test_clean_press();
    int pulses, first, other;
    evq.delete();
    pulses = 0; first = 0; other = 0;
    btn_raw_i = 4'b1011;
    for (int n = 1; n <= 4000; n++) begin
      @(negedge clk_i);
      if (press_o[2]) begin
        pulses++;
        if (first == 0) first = n;
      end
      if ((press_o & 4'b1011) != 0 || release_o != 0) other++;
    end
    vectors++;
    if (pulses !== 1 || other !== 0) begin
      miscompares++;
      $display("[TB] FAIL clean_pulses: got %0d press2 / %0d other want 1 / 0", pulses, other);
    end
    vectors++;
    if (first < 2000 || first > 4000) begin
      miscompares++;
      $display("[TB] FAIL clean_latency: got %0d cycles want 2000..4000", first);
    end
    vectors++;
    if (btn_state_o !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL clean_state: got %b want 0100", btn_state_o);
    end
    vectors++;
    if (evq.size() !== 1 || ev_at(0) !== 4'b10_00) begin
      miscompares++;
      $display("[TB] FAIL clean_event: got n=%0d w=%b want n=1 w=1000", evq.size(), ev_at(0));
    end
    btn_raw_i = 4'hF;
    repeat (4000) @(negedge clk_i);
    vectors++;
    if (btn_state_o !== 4'b0000 || evq.size() !== 2 || ev_at(1) !== 4'b10_01) begin
      miscompares++;
      $display("[TB] FAIL clean_release: got st=%b n=%0d w=%b want 0000 2 1001",
               btn_state_o, evq.size(), ev_at(1));
    end
  endtask

  task automatic test_bounce();
    int pulses, first, rels;
    logic lvl;
    evq.delete();
    pulses = 0; first = 0; rels = 0;
    // Pin 1 alternates every 1500 cycles for 10 ms; last edge (to low) at 9000.
    for (int n = 0; n < 13000; n++) begin
      lvl = (n < 10000) ? logic'(((n / 1500) % 2) != 0) : 1'b0;
      btn_raw_i = {2'b11, lvl, 1'b1};
      @(negedge clk_i);
      if (press_o[1]) begin
        pulses++;
        if (first == 0) first = n;
      end
      if (release_o != 0) rels++;
    end
    vectors++;
    if (pulses !== 1 || rels !== 0) begin
      miscompares++;
      $display("[TB] FAIL bounce_pulses: got %0d press / %0d release want 1 / 0", pulses, rels);
    end
    vectors++;
    if (first < 11000 || first > 13000) begin
      miscompares++;
      $display("[TB] FAIL bounce_latency: got cycle %0d want 11000..13000", first);
    end
    vectors++;
    if (evq.size() !== 1 || ev_at(0) !== 4'b01_00) begin
      miscompares++;
      $display("[TB] FAIL bounce_event: got n=%0d w=%b want n=1 w=0100", evq.size(), ev_at(0));
    end
    btn_raw_i = 4'hF;
    repeat (4000) @(negedge clk_i);
  endtask

  task automatic test_backpressure();
    int held_bad;
    logic [3:0] exp_ev[$];
    int base;
    event_ready_i = 1'b0;
    evq.delete();
    held_bad = 0;
    btn_raw_i = 4'b0110;
    repeat (4000) @(negedge clk_i);
    vectors++;
    if ({event_valid_o, event_idx_o, event_type_o} !== 5'b1_00_00) begin
      miscompares++;
      $display("[TB] FAIL bp_first: got v=%b i=%0d t=%b want 1 0 00",
               event_valid_o, event_idx_o, event_type_o);
    end
    // Pin 3 release then re-press while its press is still pending.
    btn_raw_i = 4'b1110;
    repeat (4000) begin
      @(negedge clk_i);
      if ({event_valid_o, event_idx_o, event_type_o} !== 5'b1_00_00) held_bad++;
    end
    vectors++;
    if (overflow_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_no_ovf: got %b want 0", overflow_o);
    end
    btn_raw_i = 4'b0110;
    repeat (3998) begin
      @(negedge clk_i);
      if ({event_valid_o, event_idx_o, event_type_o} !== 5'b1_00_00) held_bad++;
    end
    vectors++;
    if (overflow_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_ovf_set: got %b want 1", overflow_o);
    end
    ovf_clr_i = 1'b1;
    @(negedge clk_i);
    ovf_clr_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (overflow_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_ovf_clr: got %b want 0", overflow_o);
    end
    vectors++;
    if (held_bad !== 0 || evq.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL bp_hold: got %0d unstable cycles, %0d events want 0, 0",
               held_bad, evq.size());
    end
    event_ready_i = 1'b1;
    btn_raw_i     = 4'hF;
    repeat (20) @(negedge clk_i);
    exp_ev.push_back(4'b00_00);
`ifdef BTN_LONG_PRESS_EN
    exp_ev.push_back(4'b00_10);
`endif
    exp_ev.push_back(4'b11_00);
    exp_ev.push_back(4'b11_01);
    vectors++;
    if (evq.size() !== exp_ev.size()) begin
      miscompares++;
      $display("[TB] FAIL bp_drain_count: got %0d want %0d", evq.size(), exp_ev.size());
    end
    for (int i = 0; i < exp_ev.size(); i++) begin
      vectors++;
      if (ev_at(i) !== exp_ev[i]) begin
        miscompares++;
        $display("[TB] FAIL bp_drain_%0d: got %b want %b", i, ev_at(i), exp_ev[i]);
      end
    end
    base = exp_ev.size();
    repeat (4000) @(negedge clk_i);
    vectors++;
    if (evq.size() !== base + 2 || ev_at(base) !== 4'b00_01 || ev_at(base + 1) !== 4'b11_01) begin
      miscompares++;
      $display("[TB] FAIL bp_releases: got n=%0d %b %b want n=%0d 0001 1101",
               evq.size(), ev_at(base), ev_at(base + 1), base + 2);
    end
  endtask

  task automatic test_long_press();
    int delta;
    int n_exp;
    event_ready_i = 1'b1;
    evq.delete();
    btn_raw_i = 4'b1110;
    repeat (10000) @(negedge clk_i);
`ifdef BTN_LONG_PRESS_EN
    n_exp = 2;
    delta = (evq.size() >= 2) ? int'(evq[1].cyc) - int'(evq[0].cyc) : -1;
    vectors++;
    if (ev_at(1) !== 4'b00_10 || delta < 4990 || delta > 5010) begin
      miscompares++;
      $display("[TB] FAIL long_event: got w=%b dt=%0d want 0010 dt~5000", ev_at(1), delta);
    end
`else
    n_exp = 1;
    delta = 0;
`endif
    vectors++;
    if (evq.size() !== n_exp || ev_at(0) !== 4'b00_00) begin
      miscompares++;
      $display("[TB] FAIL long_hold: got n=%0d w0=%b dt=%0d want n=%0d w0=0000",
               evq.size(), ev_at(0), delta, n_exp);
    end
    btn_raw_i = 4'hF;
    repeat (4000) @(negedge clk_i);
    vectors++;
    if (evq.size() !== n_exp + 1 || ev_at(n_exp) !== 4'b00_01) begin
      miscompares++;
      $display("[TB] FAIL long_release: got n=%0d w=%b want n=%0d w=0001",
               evq.size(), ev_at(n_exp), n_exp + 1);
    end
  endtask

  task automatic test_reset_mid();
    int act;
    event_ready_i = 1'b0;
    evq.delete();
    btn_raw_i = 4'b1001;
    repeat (4000) @(negedge clk_i);
    vectors++;
    if ({event_valid_o, event_idx_o, event_type_o} !== 5'b1_01_00) begin
      miscompares++;
      $display("[TB] FAIL rm_before: got v=%b i=%0d t=%b want 1 1 00",
               event_valid_o, event_idx_o, event_type_o);
    end
    rst_i     = 1'b1;
    btn_raw_i = 4'hF;
    @(negedge clk_i);
    vectors++;
    if ({event_valid_o, btn_state_o, overflow_o} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL rm_cleared: got v=%b st=%b o=%b want 0",
               event_valid_o, btn_state_o, overflow_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i         = 1'b0;
    event_ready_i = 1'b1;
    act = 0;
    repeat (4000) begin
      @(negedge clk_i);
      if (event_valid_o || (press_o != 0) || (release_o != 0) || (btn_state_o != 0)) act++;
    end
    vectors++;
    if (act !== 0 || evq.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL rm_stale: got %0d active cycles, %0d events want 0, 0",
               act, evq.size());
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_clean_press();
    test_bounce();
    test_backpressure();
    test_long_press();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
